// File: rtl/vote_key_conditioner.sv
// Front end of the 3-input majority voter: synchronises and debounces the
// voter and confirm keys, then toggles and locks the votes a/b/c.
module vote_key_conditioner #(
  parameter int DEB_CYCLES = 20,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_a_raw,
  input  logic key_b_raw,
  input  logic key_c_raw,
  input  logic key_ok_raw,
  input  logic clr,
  output logic a,
  output logic b,
  output logic c,
  output logic vote_valid,
  output logic vote_pulse
);

  typedef enum logic {
    COLLECT = 1'b0,
    LOCKED  = 1'b1
  } state_e;

  localparam int NK   = 4;
  localparam int K_OK = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [NK-1:0]    raw;
  logic [NK-1:0]    sync1_q, sync2_q;
  logic [NK-1:0]    deb_q, deb_d, deb_dly_q;
  logic [CNT_W-1:0] cnt_q [NK];
  logic [CNT_W-1:0] cnt_d [NK];
  logic [NK-1:0]    press;

  state_e     state_q, state_d;
  logic [2:0] vote_q, vote_d;
  logic       valid_q, valid_d;
  logic       pulse_q, pulse_d;

  // Bit order: 0=A, 1=B, 2=C, 3=OK.
  assign raw = {key_ok_raw, key_c_raw, key_b_raw, key_a_raw};

  // Per-key debounce: a level change is accepted only after DEB_CYCLES
  // consecutive synchronised samples disagree with the current level.
  always_comb begin
    for (int k = 0; k < NK; k++) begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      deb_d[k] = deb_q[k];
      cnt_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == CNT_LAST) deb_d[k] = sync2_q[k];
        else                      cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  assign press = deb_q & ~deb_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      // NOTE: the counter array is tiny and must restart from zero after reset, so every entry is reset.
      for (int k = 0; k < NK; k++) cnt_q[k] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so the synchroniser chain shifts one stage per clock.
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      for (int k = 0; k < NK; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      vote_q  <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vote_q  <= vote_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
    end
  end

  // Next state: clear beats confirm, confirm beats key presses.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (!clr && press[K_OK]) state_d = LOCKED;
      LOCKED:  if (clr)                 state_d = COLLECT;
      default:                          state_d = COLLECT;
    endcase
  end

  // Registered outputs; key presses coinciding with confirm are dropped.
  always_comb begin
    vote_d  = vote_q;
    valid_d = (state_d == LOCKED);
    pulse_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (clr)               vote_d  = '0;
        else if (press[K_OK])  pulse_d = 1'b1;
        else                   vote_d  = vote_q ^ press[2:0];
      end
      LOCKED:  if (clr)        vote_d  = '0;
      default:                 vote_d  = '0;
    endcase
  end

  assign a          = vote_q[0];
  assign b          = vote_q[1];
  assign c          = vote_q[2];
  assign vote_valid = valid_q;
  assign vote_pulse = pulse_q;

endmodule
